// File: rtl/switch_scan_pkg.sv
// Shared types and constants for the switch debounce controller.
package switch_scan_pkg;

   typedef enum logic [0:0] {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } chan_state_t;

   localparam int TB_N_SW        = 4;
   localparam int TB_TICK_DIV    = 4;
   localparam int TB_N_TICKS     = 3;
   localparam int TB_SYNC_STAGES = 2;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/switch_chan_fsm.sv
// One switch channel: input synchronizer followed by the debounce FSM.
//
// state   | meaning
// STABLE  | synchronized input equals db
// PENDING | input differs from db; count holds ticks seen so far
module switch_chan_fsm
   import switch_scan_pkg::*;
#(
   parameter int N_TICKS     = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sw,
   input  logic tick,
   output logic db,
   output logic rise,
   output logic fall,
   output logic flip
);

   localparam logic [0:0] ST_STABLE  = STABLE;
   localparam logic [0:0] ST_PENDING = PENDING;

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [0:0]             state;
   logic [3:0]             count;
   logic [3:0]             count_inc;

   assign s         = sync[SYNC_STAGES-1];
   assign count_inc = count + 4'd1;
   // Combinational so the top can set the event flag on the same edge db flips.
   assign flip      = (state == ST_PENDING) && (s != db) && tick &&
                      (count_inc == 4'(N_TICKS));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync  <= '0;
         state <= ST_STABLE;
         count <= 4'd0;
         db    <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], sw};
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            ST_STABLE: begin
               if (s != db) begin
                  state <= ST_PENDING;
                  count <= 4'd0;
               end
            end
            ST_PENDING: begin
               if (s == db) begin
                  state <= ST_STABLE;
                  count <= 4'd0;
               end else if (flip) begin
                  db    <= ~db;
                  rise  <= ~db;
                  fall  <= db;
                  state <= ST_STABLE;
                  count <= 4'd0;
               end else if (tick) begin
                  count <= count_inc;
               end
            end
            default: begin
               state <= ST_STABLE;
               count <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_scan_ctrl.sv
// Debounce controller for a switch bank: shared tick prescaler, per-channel
// FSMs, and a round-robin event port with sticky overflow.
module switch_scan_ctrl
   import switch_scan_pkg::*;
#(
   parameter  int N_SW        = 4,
   parameter  int TICK_DIV    = 500000,
   parameter  int N_TICKS     = 3,
   parameter  int SYNC_STAGES = 2,
   localparam int ID_W        = id_width(N_SW),
   localparam int PW          = $clog2(TICK_DIV)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_SW-1:0] sw,
   input  logic            enable,
   output logic [N_SW-1:0] db,
   output logic [N_SW-1:0] rise,
   output logic [N_SW-1:0] fall,
   output logic            tick,
   output logic            evt_valid,
   input  logic            evt_ready,
   output logic [ID_W-1:0] evt_id,
   output logic            evt_level,
   output logic            evt_overflow,
   input  logic            clr_overflow
);

   localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]   pcnt;
   logic [N_SW-1:0] flip;
   logic [N_SW-1:0] flag;
   logic [N_SW-1:0] flag_nxt;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] ptr_nxt;
   logic [ID_W-1:0] gnt;
   logic            gnt_ok;
   logic            load;
   logic            ovf_set;

   assign tick = enable && (pcnt == PCNT_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n || !enable) begin
         pcnt <= '0;
      end else if (pcnt == PCNT_LAST) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PW'(1);
      end
   end

   for (genvar i = 0; i < N_SW; i++) begin : g_chan
      switch_chan_fsm #(
         .N_TICKS     (N_TICKS),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .sw      (sw[i]),
         .tick    (tick),
         .db      (db[i]),
         .rise    (rise[i]),
         .fall    (fall[i]),
         .flip    (flip[i])
      );
   end

   // First set flag at or above the pointer, wrapping around.
   always_comb begin
      int idx;
      idx    = 0;
      gnt_ok = 1'b0;
      gnt    = '0;
      for (int k = 0; k < N_SW; k++) begin
         idx = (int'(ptr) + k) % N_SW;
         if (!gnt_ok && flag[idx]) begin
            gnt_ok = 1'b1;
            gnt    = ID_W'(idx);
         end
      end
   end

   assign load    = gnt_ok && (!evt_valid || evt_ready);
   assign ptr_nxt = (int'(gnt) == N_SW - 1) ? '0 : gnt + ID_W'(1);

   // A fresh flip always wins over the grant so the newer event is kept.
   always_comb begin
      flag_nxt = flag;
      ovf_set  = 1'b0;
      for (int i = 0; i < N_SW; i++) begin
         if (flip[i]) begin
            flag_nxt[i] = 1'b1;
            if (flag[i] && !(load && int'(gnt) == i)) begin
               ovf_set = 1'b1;
            end
         end else if (load && int'(gnt) == i) begin
            flag_nxt[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flag         <= '0;
         ptr          <= '0;
         evt_valid    <= 1'b0;
         evt_id       <= '0;
         evt_level    <= 1'b0;
         evt_overflow <= 1'b0;
      end else begin
         flag <= flag_nxt;
         if (ovf_set) begin
            evt_overflow <= 1'b1;
         end else if (clr_overflow) begin
            evt_overflow <= 1'b0;
         end
         if (load) begin
            evt_valid <= 1'b1;
            evt_id    <= gnt;
            evt_level <= db[gnt];
            ptr       <= ptr_nxt;
         end else if (evt_ready) begin
            evt_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// Scoreboard bench for switch_scan_ctrl with directed switch sequences.
module tb_switch_scan_ctrl;
   import switch_scan_pkg::*;

   localparam int IDW = id_width(TB_N_SW);

   logic           clk = 1'b0;
   logic           reset_n;
   logic [3:0]     sw;
   logic           enable;
   logic [3:0]     db, rise, fall;
   logic           tick;
   logic           evt_valid, evt_ready, evt_level, evt_overflow, clr_overflow;
   logic [IDW-1:0] evt_id;

   int checks = 0;
   int errors = 0;

   logic [IDW:0] exp_evt[$];
   logic [11:0]  exp_edge[$];
   logic [IDW:0] mon_evt;
   logic [11:0]  mon_edge;

   switch_scan_ctrl #(
      .N_SW        (TB_N_SW),
      .TICK_DIV    (TB_TICK_DIV),
      .N_TICKS     (TB_N_TICKS),
      .SYNC_STAGES (TB_SYNC_STAGES)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sw           (sw),
      .enable       (enable),
      .db           (db),
      .rise         (rise),
      .fall         (fall),
      .tick         (tick),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_id       (evt_id),
      .evt_level    (evt_level),
      .evt_overflow (evt_overflow),
      .clr_overflow (clr_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_db(input logic [3:0] target, input int budget, input string name);
      int n;
      n = 0;
      while (db !== target && n < budget) begin
         cyc(1);
         n++;
      end
      check(name, {28'd0, db}, {28'd0, target});
   endtask

   task automatic do_reset(input logic [3:0] sw_val);
      reset_n      = 1'b0;
      sw           = sw_val;
      evt_ready    = 1'b0;
      clr_overflow = 1'b0;
      enable       = 1'b1;
      exp_evt.delete();
      exp_edge.delete();
      cyc(2);
      reset_n = 1'b1;
   endtask

   // Monitor: pops the scoreboard on every accepted event and every edge pulse.
   always @(negedge clk) begin
      if (evt_valid && evt_ready) begin
         if (exp_evt.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event actual id=%0d level=%0d required none", evt_id, evt_level);
         end else begin
            mon_evt = exp_evt.pop_front();
            check("event_record", {29'd0, evt_id, evt_level}, {29'd0, mon_evt});
         end
      end
      if ((rise | fall) != 4'h0) begin
         if (exp_edge.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_edge actual rise=%0h fall=%0h required none", rise, fall);
         end else begin
            mon_edge = exp_edge.pop_front();
            check("edge_rise_fall_db", {20'd0, rise, fall, db}, {20'd0, mon_edge});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int n;
      int cnt_a;
      int cnt_b;

      // Reset with all switches high, then all four flip together.
      reset_n = 1'b0; sw = 4'hF; enable = 1'b1; evt_ready = 1'b0; clr_overflow = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         check("reset_outputs",
               {14'd0, db, rise, fall, tick, evt_valid, evt_id, evt_level, evt_overflow}, 32'd0);
      end
      exp_edge.push_back({4'hF, 4'h0, 4'hF});
      reset_n = 1'b1;
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (db !== 4'hF && n < 20);
      check("db_latency_in_range", {31'd0, (n >= 10 && n <= 15)}, 32'd1);
      check("db_latency", n, 12);
      check("rise_all", {28'd0, rise}, 32'hF);
      cyc(1);
      check("rise_one_cycle", {28'd0, rise}, 32'h0);
      for (int k = 0; k < 10; k++) begin
         check("evt_hold", {29'd0, evt_valid, evt_id}, {29'd0, 1'b1, 2'd0});
         cyc(1);
      end
      for (int k = 0; k < 4; k++) exp_evt.push_back({2'(k), 1'b1});
      evt_ready = 1'b1;
      cyc(4);
      check("evt_drained", {31'd0, evt_valid}, 32'd0);

      // Bounce on sw[0] never settles long enough.
      do_reset(4'h0);
      evt_ready = 1'b1;
      cnt_a = 0;
      for (int k = 0; k < 20; k++) begin
         sw[0] = ~sw[0];
         for (int j = 0; j < 3; j++) begin
            cyc(1);
            cnt_a += int'(tick);
         end
      end
      check("tick_count", cnt_a, 15);
      cyc(30);
      check("bounce_db", {28'd0, db}, 32'h0);
      check("bounce_no_evt", {31'd0, evt_valid}, 32'd0);

      // Overflow: ch0 holds the register, ch2 flips twice behind it.
      do_reset(4'h0);
      exp_edge.push_back({4'h5, 4'h0, 4'h5});
      sw = 4'b0101;
      wait_db(4'h5, 20, "ovf_rise_db");
      cyc(1);
      check("ovf_first_evt", {30'd0, evt_valid, evt_id, evt_level}, {30'd0, 1'b1, 2'd0, 1'b1});
      check("ovf_clear_before", {31'd0, evt_overflow}, 32'd0);
      exp_edge.push_back({4'h0, 4'h4, 4'h1});
      sw[2] = 1'b0;
      wait_db(4'h1, 20, "ovf_fall_db");
      check("ovf_on_fall", {31'd0, evt_overflow}, 32'd1);
      clr_overflow = 1'b1;
      cyc(1);
      clr_overflow = 1'b0;
      check("ovf_cleared", {31'd0, evt_overflow}, 32'd0);
      check("evt_stable", {29'd0, evt_id, evt_level}, {29'd0, 2'd0, 1'b1});
      exp_edge.push_back({4'h4, 4'h0, 4'h5});
      clr_overflow = 1'b1;
      sw[2] = 1'b1;
      wait_db(4'h5, 20, "ovf_rise2_db");
      check("ovf_set_wins", {31'd0, evt_overflow}, 32'd1);
      clr_overflow = 1'b0;
      cyc(1);
      check("ovf_sticky", {31'd0, evt_overflow}, 32'd1);
      exp_evt.push_back({2'd0, 1'b1});
      exp_evt.push_back({2'd2, 1'b1});
      evt_ready = 1'b1;
      cyc(3);
      check("ovf_drained", {31'd0, evt_valid}, 32'd0);

      // Enable hold: one tick counted, prescaler frozen, then two more ticks.
      do_reset(4'h0);
      evt_ready = 1'b1;
      exp_edge.push_back({4'h2, 4'h0, 4'h2});
      exp_evt.push_back({2'd1, 1'b1});
      sw = 4'b0010;
      cyc(3);
      n = 0;
      while (!tick && n < 10) begin
         cyc(1);
         n++;
      end
      check("tick_seen", {31'd0, tick}, 32'd1);
      cyc(1);
      enable = 1'b0;
      cnt_a = 0;
      cnt_b = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         cnt_a += int'(tick);
         if (db != 4'h0) cnt_b++;
      end
      check("hold_no_tick", cnt_a, 0);
      check("hold_db_unchanged", cnt_b, 0);
      enable = 1'b1;
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (db !== 4'h2 && n < 30);
      check("reenable_latency", n, 8);

      // Mid-operation reset with an unaccepted event and a pending channel.
      cyc(2);
      evt_ready = 1'b0;
      exp_edge.push_back({4'h8, 4'h0, 4'hA});
      sw = 4'b1010;
      wait_db(4'hA, 20, "mid_db");
      cyc(1);
      check("mid_evt", {29'd0, evt_valid, evt_id}, {29'd0, 1'b1, 2'd3});
      sw = 4'b1011;
      cyc(3);
      reset_n = 1'b0;
      sw = 4'h0;
      cyc(1);
      check("mid_reset_state", {15'd0, evt_valid, evt_id, evt_level, db, evt_overflow, rise, fall}, 32'd0);
      reset_n = 1'b1;
      evt_ready = 1'b1;
      cnt_a = 0;
      for (int k = 0; k < 30; k++) begin
         cyc(1);
         cnt_a += int'(evt_valid);
      end
      check("no_stale_event", cnt_a, 0);
      check("mid_db_after", {28'd0, db}, 32'h0);

      check("evt_queue_empty", exp_evt.size(), 0);
      check("edge_queue_empty", exp_edge.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_scan_ctrl.md
Name: switch_scan_ctrl

Overview:
Debounce controller for a bank of N_SW mechanical switches. It owns the single shared tick prescaler and sequences one small per-channel debounce FSM for every switch. It reports each debounced transition as a level, as one-cycle rise/fall pulses, and as an event record on a valid/ready port. A round-robin arbiter shares that event port between the channels. The block sits between the board switch pins and the control logic.

Parameters:
N_SW, 4, number of switch channels (1..16)
TICK_DIV, 500000, clk cycles per debounce tick (>=2)
N_TICKS, 3, ticks a new level must persist before db changes (1..15)
SYNC_STAGES, 2, input synchronizer flops per channel (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
sw  in  N_SW  raw asynchronous switch inputs
enable  in  1  1 = prescaler runs; 0 = prescaler cleared and held
db  out  N_SW  debounced levels
rise  out  N_SW  one-cycle pulse, same cycle db[i] goes 0->1
fall  out  N_SW  one-cycle pulse, same cycle db[i] goes 1->0
tick  out  1  one-cycle prescaler strobe
evt_valid  out  1  event record valid
evt_ready  in  1  consumer accepts event
evt_id  out  max(1,$clog2(N_SW))  channel index of the event
evt_level  out  1  db value of that channel when the record was loaded
evt_overflow  out  1  sticky: a channel flipped again before its prior event was reported
clr_overflow  in  1  clears evt_overflow

Behaviour:
- Reset (reset_n=0 at a clk edge) clears everything:
  - db=0, rise=0, fall=0, tick=0.
  - evt_valid=0, evt_id=0, evt_level=0, evt_overflow=0.
  - Prescaler=0, all channel FSMs in STABLE with count 0.
  - Synchronizers=0, all event flags clear, round-robin pointer=0.
- Reset applied mid-operation discards pending counts and any unaccepted event.
- Synchronizer: each sw[i] passes through SYNC_STAGES flops; s[i] is the last stage.
- Prescaler: while enable=1, counts 0..TICK_DIV-1 and wraps. tick=1 for the one cycle where count==TICK_DIV-1. While enable=0, count is forced to 0 and tick=0.
- Per-channel FSM, states STABLE and PENDING, 4-bit count:
  - STABLE: if s[i]!=db[i], go to PENDING with count=0; otherwise stay.
  - PENDING, s[i]==db[i] (any cycle, tick or not): go to STABLE, count=0, no output change.
  - PENDING, s[i]!=db[i] and tick: count+1. When count+1==N_TICKS, flip db[i], pulse rise[i]/fall[i] that same cycle, set event flag f[i], and go to STABLE.
- Stable time required: db flips after more than (N_TICKS-1)*TICK_DIV and at most N_TICKS*TICK_DIV cycles of a constant s[i].
- Event flags and overflow:
  - A flip when f[i] is already set and not being granted that cycle sets evt_overflow; f[i] stays set.
  - Flip and grant of the same channel in the same cycle: f[i] stays set (the new event is kept).
  - clr_overflow clears evt_overflow; a set in the same cycle wins.
- Event register:
  - Loads when evt_valid==0, or evt_valid&&evt_ready, and at least one f[i] is set.
  - Grant goes to the first set flag searching upward from the pointer, wrapping.
  - On load: evt_id=grant, evt_level=db[grant] (registered value), f[grant] cleared, pointer=grant+1 mod N_SW.
  - On acceptance with no flags set, evt_valid drops to 0 next cycle.
  - While evt_valid&&!evt_ready, evt_id and evt_level hold stable.
  - Throughput: one event per cycle.

Decomposition:
- Package switch_scan_pkg holds:
  - the chan_state_t enum {STABLE, PENDING};
  - the ID width function;
  - constants shared with the bench.
- One sub-module, switch_chan_fsm: synchronizer plus per-channel FSM plus count, instantiated N_SW times in a generate loop.
- Prescaler, arbiter and event register stay in the top.

Test Plan:
(All tests use N_SW=4, TICK_DIV=4, N_TICKS=3, SYNC_STAGES=2, enable=1 unless stated.)
1. Reset: hold reset_n=0 for 3 cycles with sw=4'hF, then release -> during reset all outputs 0. db becomes 4'hF within 10..15 cycles of release. rise=4'hF for exactly that one cycle.
2. Bounce: toggle sw[0] every 3 cycles for 60 cycles, then hold 0 -> db[0]=0, no rise[0], evt_valid stays 0.
3. Round robin: flip all four channels in the same cycle with evt_ready=0 -> evt_valid=1, evt_id=0 held for 10 cycles. Then evt_ready=1 -> evt_id 0,1,2,3 on consecutive cycles with evt_level=1, then evt_valid=0.
4. Overflow: with evt_ready=0, debounce sw[2] high, then low -> evt_overflow=1 on the falling flip. Pulse clr_overflow -> evt_overflow=0 next cycle. Set and clear in the same cycle -> stays 1.
5. Enable hold: after 1 tick in PENDING, drive enable=0 for 20 cycles -> tick=0 and db unchanged. Re-enable -> db flips after 2 further ticks (about 8 cycles).
6. Reset mid-operation: assert reset_n=0 for 1 cycle while evt_valid=1 and a channel is PENDING -> next cycle evt_valid=0, db=0, all flags cleared, no stale event afterwards.
